// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequencing FSM for the multiply-accumulate datapath.
// Clears acc, pulls len operand pairs, holds the result on a handshake.
module mac_seq_ctrl #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ld_op,
  output logic             ld_acc,
  output logic             acc_zero,
  output logic             busy,
  output logic [LEN_W-1:0] term_idx,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    ACC,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx_q;
  logic [LEN_W-1:0] idx_d;
  logic [LEN_W-1:0] idx_inc;

  logic fetch_q;
  logic ld_acc_q;
  logic acc_zero_q;
  logic busy_q;
  logic out_valid_q;

  assign idx_inc = idx_q + LEN_W'(1);

  // Next state and term counter; abort overrides every busy state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        idx_d   = '0;
        state_d = (len_q == '0) ? DONE : FETCH;
      end
      FETCH: begin
        if (in_valid) state_d = ACC;
      end
      ACC: begin
        idx_d   = idx_inc;
        state_d = (idx_inc == len_q) ? DONE : FETCH;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) state_d = IDLE;
  end

  // State, job length and output flags all registered from next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      fetch_q     <= 1'b0;
      ld_acc_q    <= 1'b0;
      acc_zero_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if ((state_q == IDLE) && start) len_q <= len;
      fetch_q     <= (state_d == FETCH);
      ld_acc_q    <= (state_d == CLEAR) || (state_d == ACC);
      acc_zero_q  <= (state_d == CLEAR);
      busy_q      <= (state_d != IDLE);
      out_valid_q <= (state_d == DONE);
    end
  end

  // An aborting FETCH must not take the pair it sees.
  assign in_ready  = fetch_q & ~abort;
  assign ld_op     = fetch_q & in_valid & ~abort;
  assign ld_acc    = ld_acc_q;
  assign acc_zero  = acc_zero_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign term_idx  = idx_q;

endmodule
